// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types and default constants for the alarm sounder sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } ring_state_t;

  localparam int TIME_W             = 32'sd14;
  localparam int DEF_CLK_HZ         = 32'sd10000;
  localparam int DEF_BEEP_ON        = 32'sd2000;
  localparam int DEF_BEEP_PERIOD    = 32'sd5000;
  localparam int DEF_RING_TIMEOUT_S = 32'sd60;
  localparam int DEF_SNOOZE_S       = 32'sd300;
  localparam int DEF_MAX_SNOOZE     = 32'sd3;

  function automatic int cnt_w(input int terminal);
    return $clog2(terminal) + 32'sd1;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Time/alarm/button inputs and sounder status outputs of the alarm sequencer.
interface alarm_ring_ctrl_if;
  import alarm_pkg::*;

  logic              alarm_enable;
  logic [TIME_W-1:0] hour;
  logic [TIME_W-1:0] minute;
  logic [TIME_W-1:0] second;
  logic [TIME_W-1:0] alarm_hour;
  logic [TIME_W-1:0] alarm_minute;
  logic              snooze;
  logic              dismiss;
  logic              beep;
  logic              ringing;
  logic              snoozing;
  logic              missed;
  logic [1:0]        snooze_cnt;
  logic [1:0]        ring_state;

  modport master (
    output alarm_enable, hour, minute, second, alarm_hour, alarm_minute, snooze, dismiss,
    input  beep, ringing, snoozing, missed, snooze_cnt, ring_state
  );

  modport slave (
    input  alarm_enable, hour, minute, second, alarm_hour, alarm_minute, snooze, dismiss,
    output beep, ringing, snoozing, missed, snooze_cnt, ring_state
  );

endinterface

// File: rtl/alarm_ring_ctrl_sec_tick_gen.sv
// One-second tick generator: counts clock ticks and flags the last tick of each second.
module sec_tick_gen
  import alarm_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);

  localparam int            TW         = cnt_w(CLK_HZ);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 32'sd1);
  localparam logic [TW-1:0] TICK_ZERO  = TW'(32'sd0);
  localparam logic [TW-1:0] TICK_ONE   = TW'(32'sd1);

  logic [TW-1:0] tick_cnt_r;

  // Tick counter; clear restarts the second so it lines up with a state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= TICK_ZERO;
    end else if (clear || (tick_cnt_r == TICK_LAST)) begin
      tick_cnt_r <= TICK_ZERO;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  assign sec_tick = (tick_cnt_r == TICK_LAST);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder sequencer: detects the alarm minute, pulses the beeper, handles
// bounded snoozes, dismiss and the unanswered-ring timeout.
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int BEEP_ON        = DEF_BEEP_ON,
  parameter int BEEP_PERIOD    = DEF_BEEP_PERIOD,
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic             clk,
  input  logic             reset,
  alarm_ring_ctrl_if.slave bus
);

  localparam int            PW          = cnt_w(BEEP_PERIOD);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(BEEP_PERIOD - 32'sd1);
  localparam logic [PW-1:0] PHASE_ZERO  = PW'(32'sd0);
  localparam logic [PW-1:0] PHASE_ONE   = PW'(32'sd1);
  localparam logic [PW-1:0] BEEP_ON_V   = PW'(BEEP_ON);

  localparam int            SEC_TERM    = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int            SW          = cnt_w(SEC_TERM);
  localparam logic [SW-1:0] RING_LAST   = SW'(RING_TIMEOUT_S - 32'sd1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_S - 32'sd1);
  localparam logic [SW-1:0] SEC_ZERO    = SW'(32'sd0);
  localparam logic [SW-1:0] SEC_ONE     = SW'(32'sd1);

  // snooze_cnt is exposed on a 2-bit port, so MAX_SNOOZE is limited to 3.
  localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);
  localparam logic [1:0]        SNZ_ZERO  = 2'b00;
  localparam logic [1:0]        SNZ_ONE   = 2'b01;
  localparam logic [TIME_W-1:0] TIME_ZERO = {TIME_W{1'b0}};

  ring_state_t state_r, state_next_s;
  logic [PW-1:0] phase_cnt_r, phase_next_s;
  logic [SW-1:0] sec_cnt_r, sec_next_s, sec_last_s;
  logic [1:0]    snooze_cnt_r, snooze_cnt_next_s;
  logic          missed_r, missed_next_s;
  logic          match_s, match_d_r, trigger_s;
  logic          sec_tick_s, sec_done_s, cnt_clear_s;
  logic          beep_r, beep_next_s, ringing_r, snoozing_r;

  assign match_s    = bus.alarm_enable
                    & (bus.hour   == bus.alarm_hour)
                    & (bus.minute == bus.alarm_minute)
                    & (bus.second == TIME_ZERO);
  assign trigger_s  = match_s & ~match_d_r;
  assign sec_last_s = (state_r == SNOOZE) ? SNOOZE_LAST : RING_LAST;
  assign sec_done_s = sec_tick_s & (sec_cnt_r == sec_last_s);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .sec_tick (sec_tick_s)
  );

  // Next-state logic; alarm_enable low overrides everything, then dismiss > snooze > timeout.
  always_comb begin
    state_next_s      = state_r;
    snooze_cnt_next_s = snooze_cnt_r;
    missed_next_s     = missed_r;
    if (!bus.alarm_enable) begin
      state_next_s      = IDLE;
      snooze_cnt_next_s = SNZ_ZERO;
      missed_next_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_next_s      = RINGING;
            snooze_cnt_next_s = SNZ_ZERO;
            missed_next_s     = 1'b0;
          end else if (bus.dismiss) begin
            missed_next_s = 1'b0;
          end else begin
            missed_next_s = missed_r;
          end
        end
        RINGING: begin
          if (bus.dismiss) begin
            state_next_s      = IDLE;
            snooze_cnt_next_s = SNZ_ZERO;
          end else if (bus.snooze && (snooze_cnt_r < SNZ_MAX)) begin
            state_next_s      = SNOOZE;
            snooze_cnt_next_s = snooze_cnt_r + SNZ_ONE;
          end else if (sec_done_s) begin
            state_next_s  = IDLE;
            missed_next_s = 1'b1;
          end else begin
            state_next_s = RINGING;
          end
        end
        SNOOZE: begin
          if (bus.dismiss) begin
            state_next_s      = IDLE;
            snooze_cnt_next_s = SNZ_ZERO;
          end else if (sec_done_s) begin
            state_next_s = RINGING;
          end else begin
            state_next_s = SNOOZE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Counter next values; any state change or IDLE restarts the second and phase counters.
  always_comb begin
    cnt_clear_s = (state_r == IDLE) || (state_next_s != state_r);
    if ((state_r == RINGING) && (state_next_s == RINGING)) begin
      phase_next_s = (phase_cnt_r == PHASE_LAST) ? PHASE_ZERO : (phase_cnt_r + PHASE_ONE);
    end else begin
      phase_next_s = PHASE_ZERO;
    end
    if (cnt_clear_s) begin
      sec_next_s = SEC_ZERO;
    end else if (sec_tick_s) begin
      sec_next_s = (sec_cnt_r == sec_last_s) ? SEC_ZERO : (sec_cnt_r + SEC_ONE);
    end else begin
      sec_next_s = sec_cnt_r;
    end
    beep_next_s = (state_next_s == RINGING) && (phase_next_s < BEEP_ON_V);
  end

  // State, counters and outputs all commit on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      phase_cnt_r  <= PHASE_ZERO;
      sec_cnt_r    <= SEC_ZERO;
      snooze_cnt_r <= SNZ_ZERO;
      missed_r     <= 1'b0;
      match_d_r    <= 1'b0;
      beep_r       <= 1'b0;
      ringing_r    <= 1'b0;
      snoozing_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      phase_cnt_r  <= phase_next_s;
      sec_cnt_r    <= sec_next_s;
      snooze_cnt_r <= snooze_cnt_next_s;
      missed_r     <= missed_next_s;
      match_d_r    <= match_s;
      beep_r       <= beep_next_s;
      ringing_r    <= (state_next_s == RINGING);
      snoozing_r   <= (state_next_s == SNOOZE);
    end
  end

  assign bus.beep       = beep_r;
  assign bus.ringing    = ringing_r;
  assign bus.snoozing   = snoozing_r;
  assign bus.missed     = missed_r;
  assign bus.snooze_cnt = snooze_cnt_r;
  assign bus.ring_state = state_r;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed scoreboard bench for alarm_ring_ctrl with shortened timing parameters.
module tb_alarm_ring_ctrl;
  import alarm_pkg::*;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_entry_t;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RING = 2'b01;
  localparam logic [1:0] S_SNZ  = 2'b10;

  logic      clk;
  logic      reset;
  int        n_assert;
  int        n_fail;
  sb_entry_t sb_q[$];

  alarm_ring_ctrl_if bus();

  alarm_ring_ctrl #(
    .CLK_HZ         (10),
    .BEEP_ON        (2),
    .BEEP_PERIOD    (4),
    .RING_TIMEOUT_S (3),
    .SNOOZE_S       (2),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector {ring_state, beep, ringing, snoozing, missed, snooze_cnt}.
  function automatic logic [7:0] outs(input logic [1:0] st, input logic b, input logic m,
                                      input logic [1:0] sc);
    return {st, b, (st == S_RING), (st == S_SNZ), m, sc};
  endfunction

  // Beep pattern 1,1,0,0 for k cycles after entering RINGING.
  function automatic logic beep_at(input int k);
    return ((k % 4) < 2);
  endfunction

  task automatic cycle(input string t, input logic [7:0] x);
    sb_entry_t  e;
    logic [7:0] obs;
    sb_q.push_back('{t, x});
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {bus.ring_state, bus.beep, bus.ringing, bus.snoozing, bus.missed, bus.snooze_cnt};
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.alarm_enable = 1'b0;
    bus.hour         = 14'd7;
    bus.minute       = 14'd29;
    bus.second       = 14'd59;
    bus.alarm_hour   = 14'd7;
    bus.alarm_minute = 14'd30;
    bus.snooze       = 1'b0;
    bus.dismiss      = 1'b0;

    cycle("reset", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    cycle("reset_hold", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    reset            = 1'b0;
    bus.alarm_enable = 1'b1;
    cycle("pre_match_075959", outs(S_IDLE, 1'b0, 1'b0, 2'd0));

    // 07:30:00 held: ring pattern, timeout after 3 s, no retrigger while second stays 0.
    bus.minute = 14'd30;
    bus.second = 14'd0;
    for (int k = 0; k < 35; k++) begin
      if (k < 30) cycle("ring_pattern", outs(S_RING, beep_at(k), 1'b0, 2'd0));
      else        cycle("timeout_missed", outs(S_IDLE, 1'b0, 1'b1, 2'd0));
    end

    bus.alarm_enable = 1'b0;
    cycle("enable_low_clears_missed", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    bus.alarm_enable = 1'b1;
    cycle("retrigger_on_enable", outs(S_RING, 1'b1, 1'b0, 2'd0));
    cycle("ring_k1", outs(S_RING, 1'b1, 1'b0, 2'd0));

    // First snooze: 20 silent cycles then ringing restarts at phase 0.
    bus.snooze = 1'b1;
    cycle("snooze1_enter", outs(S_SNZ, 1'b0, 1'b0, 2'd1));
    bus.snooze = 1'b0;
    for (int j = 1; j < 20; j++) cycle("snooze1_quiet", outs(S_SNZ, 1'b0, 1'b0, 2'd1));
    for (int k = 0; k < 3; k++) cycle("resume1", outs(S_RING, beep_at(k), 1'b0, 2'd1));

    bus.snooze = 1'b1;
    cycle("snooze2_enter", outs(S_SNZ, 1'b0, 1'b0, 2'd2));
    bus.snooze = 1'b0;
    for (int j = 1; j < 20; j++) cycle("snooze2_quiet", outs(S_SNZ, 1'b0, 1'b0, 2'd2));
    cycle("resume2", outs(S_RING, 1'b1, 1'b0, 2'd2));

    // Third snooze exceeds the limit and is ignored.
    bus.snooze = 1'b1;
    cycle("snooze_limit_ignored", outs(S_RING, 1'b1, 1'b0, 2'd2));
    bus.snooze = 1'b0;
    cycle("snooze_limit_ring", outs(S_RING, 1'b0, 1'b0, 2'd2));

    bus.snooze  = 1'b1;
    bus.dismiss = 1'b1;
    cycle("snooze_and_dismiss", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    bus.snooze  = 1'b0;
    bus.dismiss = 1'b0;
    cycle("idle_no_retrigger", outs(S_IDLE, 1'b0, 1'b0, 2'd0));

    bus.second = 14'd1;
    cycle("second1_idle", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    bus.second = 14'd0;
    cycle("trigger_again", outs(S_RING, 1'b1, 1'b0, 2'd0));

    // Reset mid-ring clears match_d too, so the still-matching time triggers again.
    reset = 1'b1;
    cycle("reset_mid_ring", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    reset = 1'b0;
    cycle("post_reset_trigger", outs(S_RING, 1'b1, 1'b0, 2'd0));
    cycle("post_reset_k1", outs(S_RING, 1'b1, 1'b0, 2'd0));
    bus.alarm_enable = 1'b0;
    cycle("enable_low_mid_ring", outs(S_IDLE, 1'b0, 1'b0, 2'd0));

    // Second timeout, then dismiss in IDLE clears missed.
    bus.alarm_enable = 1'b1;
    for (int k = 0; k < 31; k++) begin
      if (k < 30) cycle("ring_pattern2", outs(S_RING, beep_at(k), 1'b0, 2'd0));
      else        cycle("timeout_missed2", outs(S_IDLE, 1'b0, 1'b1, 2'd0));
    end
    bus.dismiss = 1'b1;
    cycle("dismiss_idle_clears_missed", outs(S_IDLE, 1'b0, 1'b0, 2'd0));
    bus.dismiss = 1'b0;
    cycle("idle_final", outs(S_IDLE, 1'b0, 1'b0, 2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
Sequences the alarm sounder for the clock design. It compares running time against the stored alarm time, then drives a pulsed beep pattern. It supports snooze with a bounded repeat count and auto-stops after a ring timeout. It sits between the time counter, alarm-register and debounce outputs and the top-level beep pin, running on the 10 kHz counter clock.

Parameters:
CLK_HZ, 10000, clock ticks per second
BEEP_ON, 2000, ticks beep is high in each pattern period
BEEP_PERIOD, 5000, ticks per beep pattern period (BEEP_ON < BEEP_PERIOD)
RING_TIMEOUT_S, 60, seconds of unanswered ringing before auto-stop
SNOOZE_S, 300, snooze duration in seconds
MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
clk  in  1  counter clock (10 kHz); one clock
reset  in  1  synchronous, active-high reset
alarm_enable  in  1  level; alarm armed
hour  in  14  current hour, binary 0..23
minute  in  14  current minute, binary 0..59
second  in  14  current second, binary 0..59
alarm_hour  in  14  stored alarm hour
alarm_minute  in  14  stored alarm minute
snooze  in  1  one-cycle pulse (debounced inc_short edge)
dismiss  in  1  one-cycle pulse (debounced set edge)
beep  out  1  sounder drive
ringing  out  1  high in RINGING
snoozing  out  1  high in SNOOZE
missed  out  1  sticky; ring timed out unanswered
snooze_cnt  out  2  snoozes used this event
ring_state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE

Behaviour:
- Reset, sampled on posedge clk: state IDLE. All outputs 0. All counters 0, including match_d.
- All outputs are registered. Each output reflects the state and counters committed at the same edge.
- match = alarm_enable & hour==alarm_hour & minute==alarm_minute & second==0. match_d is match delayed one cycle.
- trigger = match & ~match_d. This gives a single trigger per alarm minute.
- IDLE:
  - On trigger, go to RINGING.
  - Clear phase_cnt, tick_cnt, sec_cnt and snooze_cnt.
  - Clear missed.
- RINGING:
  - phase_cnt counts 0..BEEP_PERIOD-1 and wraps.
  - beep = (phase_cnt < BEEP_ON). Beep is therefore 1 in the first RINGING cycle.
  - tick_cnt counts 0..CLK_HZ-1. Each wrap increments sec_cnt.
  - Event priority within one cycle: alarm_enable low > dismiss > snooze > timeout.
  - dismiss: go to IDLE and clear snooze_cnt.
  - snooze with snooze_cnt < MAX_SNOOZE: go to SNOOZE, increment snooze_cnt, clear tick_cnt and sec_cnt.
  - snooze with snooze_cnt == MAX_SNOOZE: ignored; keep ringing.
  - sec_cnt reaching RING_TIMEOUT_S: go to IDLE and set missed.
- SNOOZE:
  - beep is 0.
  - tick_cnt and sec_cnt count as in RINGING.
  - sec_cnt reaching SNOOZE_S: go to RINGING. Clear phase_cnt, tick_cnt and sec_cnt.
  - dismiss: go to IDLE and clear snooze_cnt.
  - snooze pulse: ignored.
- Any state with alarm_enable low: go to IDLE next edge. Force beep 0, clear snooze_cnt, clear missed.
- A trigger arriving while in RINGING or SNOOZE is ignored.
- missed clears on the next trigger, on dismiss in IDLE, or on alarm_enable low.
- Counter widths are $clog2 of each terminal value + 1. There is no arithmetic overflow: every counter resets at its terminal value.
- Reset mid-ring: beep is 0 after that edge, and state is IDLE.

Decomposition:
- Package alarm_pkg holds:
  - ring_state_t enum: IDLE=2'b00, RINGING=2'b01, SNOOZE=2'b10.
  - Default parameter constants.
- Sub-module sec_tick_gen contains tick_cnt. It has inputs clk, reset and clear, and outputs a one-cycle sec_tick at each wrap.
- sec_cnt and phase_cnt stay in alarm_ring_ctrl.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=10, BEEP_ON=2, BEEP_PERIOD=4, RING_TIMEOUT_S=3, SNOOZE_S=2, MAX_SNOOZE=2.
1. Alarm 07:30, time steps 07:29:59 -> 07:30:00 with enable=1 -> ring_state=01 next edge; beep pattern 1,1,0,0 repeating.
2. Ringing, no input for 30 cycles -> ring_state=00, missed=1, beep=0; second==0 held high throughout causes no re-trigger.
3. Ringing, snooze pulse -> ring_state=10, snooze_cnt=1, beep=0 for 20 cycles; then 01 with beep=1.
4. Two snoozes taken, third snooze pulse while ringing -> stays 01, snooze_cnt=2.
5. Snooze and dismiss in the same cycle -> ring_state=00, snooze_cnt=0.
6. Reset or alarm_enable=0 while ringing with beep=1 -> next edge beep=0, ring_state=00, missed=0.
